// File: rtl/uart_cmd_ctrl.sv
// Turns a framed UART byte stream (SYNC, ADDR_HI, ADDR_LO, COUNT, DATA...) into
// single-entry buffered writes into a text buffer, with range, overflow and timeout aborts.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         ADDR_WIDTH     = 12,
  parameter int         MAX_ADDR       = 2399,
  parameter int         TIMEOUT_CYCLES = 10210000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rx_wr_i,
  input  logic [7:0]            rx_data_i,
  output logic                  buf_we_o,
  input  logic                  buf_ready_i,
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  output logic [7:0]            buf_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int                    TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MAX_ADDR);
  localparam logic [15:0]           MAX16    = 16'(MAX_ADDR);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, COUNT, DATA} state_t;

  state_t                  state_q;
  logic                    rx_wr_q;
  logic [7:0]              addr_hi_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              hold_q;
  logic                    pending_q;
  logic [8:0]              cnt_q;
  logic [TW-1:0]           tmo_q;
  logic                    done_q;
  logic                    err_q;

  logic                    acc;
  logic                    wr_fire;
  logic                    tmo_hit;
  logic [15:0]             rx_addr;
  logic [ADDR_WIDTH-1:0]   ptr_d;

  assign acc     = rx_wr_i & ~rx_wr_q;
  assign wr_fire = pending_q & buf_ready_i;
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);
  assign rx_addr = {addr_hi_q, rx_data_i};
  assign ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

  // The write address is latched together with the data so that a new packet
  // may reload the pointer while the previous write is still stalled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      rx_wr_q   <= 1'b0;
      addr_hi_q <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_wr_q <= rx_wr_i;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (wr_fire) pending_q <= 1'b0;
      if (state_q == IDLE || acc) tmo_q <= '0;
      else                        tmo_q <= tmo_q + 1'b1;

      if (tmo_hit) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
      end else if (acc) begin
        unique case (state_q)
          IDLE: if (rx_data_i == SYNC_BYTE) state_q <= ADDR_HI;
          ADDR_HI: begin
            addr_hi_q <= rx_data_i;
            state_q   <= ADDR_LO;
          end
          ADDR_LO: begin
            if (rx_addr > MAX16) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              ptr_q   <= ADDR_WIDTH'(rx_addr);
              state_q <= COUNT;
            end
          end
          COUNT: begin
            cnt_q   <= (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
            state_q <= DATA;
          end
          DATA: begin
            // A byte arriving while the holder is still full and not draining is lost.
            if (pending_q && !buf_ready_i) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              hold_q    <= rx_data_i;
              addr_q    <= ptr_q;
              ptr_q     <= ptr_d;
              pending_q <= 1'b1;
              cnt_q     <= cnt_q - 1'b1;
              if (cnt_q == 9'd1) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign buf_we_o   = pending_q;
  assign buf_addr_o = addr_q;
  assign buf_data_o = hold_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: drives byte packets and compares logged
// buffer writes and done/err pulses against hand-computed expectations.
module tb_uart_cmd_ctrl;

  localparam int TMO = 25000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxWr = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        bufReady = 1'b1;
  logic        bufWe;
  logic [11:0] bufAddr;
  logic [7:0]  bufData;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int errCount = 0;
  logic [11:0] wrAddr[$];
  logic [7:0]  wrData[$];
  int baseW, baseDone, baseErr;
  logic [7:0] pkt[$];

  uart_cmd_ctrl #(
    .SYNC_BYTE(8'hAA), .ADDR_WIDTH(12), .MAX_ADDR(2399), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .rx_wr_i(rxWr), .rx_data_i(rxData),
    .buf_we_o(bufWe), .buf_ready_i(bufReady), .buf_addr_o(bufAddr),
    .buf_data_o(bufData), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // Inputs change just after rising edges, so the falling edge sees what the next edge will act on.
  always @(negedge clk) begin
    if (rstn) begin
      if (bufWe && bufReady) begin
        wrAddr.push_back(bufAddr);
        wrData.push_back(bufData);
      end
      if (done) doneCount++;
      if (err) errCount++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    baseW = wrAddr.size();
    baseDone = doneCount;
    baseErr = errCount;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    rxWr = 1'b1;
    rxData = b;
    repeat (hold) @(posedge clk);
    #1;
    rxWr = 1'b0;
    rxData = 8'h00;
    repeat (2) @(posedge clk);
  endtask

  task automatic sendPacket();
    foreach (pkt[i]) applyStimulus(pkt[i], 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input int k, input logic [11:0] a, input logic [7:0] d);
    if (baseW + k < wrAddr.size()) begin
      checkOutput({tag, "_addr"}, 32'(wrAddr[baseW + k]), 32'(a));
      checkOutput({tag, "_data"}, 32'(wrData[baseW + k]), 32'(d));
    end else begin
      checkOutput({tag, "_missing"}, 32'(wrAddr.size() - baseW), 32'(k + 1));
    end
  endtask

  task automatic checkCounts(input string tag, input int w, input int dn, input int er);
    checkOutput({tag, "_writes"}, 32'(wrAddr.size() - baseW), 32'(w));
    checkOutput({tag, "_done"}, 32'(doneCount - baseDone), 32'(dn));
    checkOutput({tag, "_err"}, 32'(errCount - baseErr), 32'(er));
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_we", 32'(bufWe), 32'd0);
    checkOutput("rst_addr", 32'(bufAddr), 32'd0);
    checkOutput("rst_data", 32'(bufData), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;

    $display("[TB] basic three-byte packet");
    mark();
    pkt = '{8'hAA, 8'h00, 8'h05, 8'h03, 8'h41, 8'h42, 8'h43};
    sendPacket();
    settle(4);
    checkCounts("basic", 3, 1, 0);
    checkWrite("basic0", 0, 12'd5, 8'h41);
    checkWrite("basic1", 1, 12'd6, 8'h42);
    checkWrite("basic2", 2, 12'd7, 8'h43);
    checkOutput("basic_busy", 32'(busy), 32'd0);

    $display("[TB] pointer wrap at last cell");
    mark();
    pkt = '{8'hAA, 8'h09, 8'h5F, 8'h02, 8'h58, 8'h59};
    sendPacket();
    settle(4);
    checkCounts("wrap", 2, 1, 0);
    checkWrite("wrap0", 0, 12'd2399, 8'h58);
    checkWrite("wrap1", 1, 12'd0, 8'h59);

    $display("[TB] address out of range");
    mark();
    pkt = '{8'hAA, 8'h09, 8'h60};
    sendPacket();
    settle(2);
    checkCounts("range", 0, 0, 1);
    checkOutput("range_busy", 32'(busy), 32'd0);
    mark();
    pkt = '{8'hAA, 8'h00, 8'h01, 8'h01, 8'h77};
    sendPacket();
    settle(4);
    checkCounts("after_range", 1, 1, 0);
    checkWrite("after_range0", 0, 12'd1, 8'h77);

    $display("[TB] stalled buffer overflow");
    mark();
    bufReady = 1'b0;
    pkt = '{8'hAA, 8'h00, 8'h00, 8'h02, 8'h11};
    sendPacket();
    checkOutput("stall_we", 32'(bufWe), 32'd1);
    checkOutput("stall_addr", 32'(bufAddr), 32'd0);
    checkOutput("stall_data", 32'(bufData), 32'h11);
    applyStimulus(8'h22, 1);
    settle(2);
    checkCounts("overflow", 0, 0, 1);
    checkOutput("overflow_busy", 32'(busy), 32'd0);
    checkOutput("overflow_we", 32'(bufWe), 32'd1);
    checkOutput("overflow_data", 32'(bufData), 32'h11);
    bufReady = 1'b1;
    settle(3);
    checkCounts("drain", 1, 0, 1);
    checkWrite("drain0", 0, 12'd0, 8'h11);
    checkOutput("drain_we", 32'(bufWe), 32'd0);

    $display("[TB] long rx_wr level yields one byte");
    mark();
    pkt = '{8'hAA, 8'h00, 8'h20, 8'h02};
    sendPacket();
    applyStimulus(8'h33, 20000);
    applyStimulus(8'h44, 1);
    settle(4);
    checkCounts("hold", 2, 1, 0);
    checkWrite("hold0", 0, 12'h020, 8'h33);
    checkWrite("hold1", 1, 12'h021, 8'h44);

    $display("[TB] inter-byte timeout");
    mark();
    pkt = '{8'hAA, 8'h00, 8'h10};
    sendPacket();
    checkOutput("tmo_busy_before", 32'(busy), 32'd1);
    n = 0;
    while (errCount == baseErr && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_not_early", 32'(n >= TMO - 50), 32'd1);
    settle(2);
    checkCounts("tmo", 0, 0, 1);
    checkOutput("tmo_busy", 32'(busy), 32'd0);

    $display("[TB] reset with a write pending");
    mark();
    bufReady = 1'b0;
    pkt = '{8'hAA, 8'h00, 8'h30, 8'h03, 8'h55};
    sendPacket();
    checkOutput("rstmid_we_before", 32'(bufWe), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checkOutput("rstmid_we", 32'(bufWe), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_addr", 32'(bufAddr), 32'd0);
    settle(3);
    rstn = 1'b1;
    bufReady = 1'b1;
    settle(10);
    checkCounts("rstmid", 0, 0, 0);
    checkOutput("rstmid_busy_after", 32'(busy), 32'd0);

    $display("[TB] rx_wr high across reset release");
    @(posedge clk); #1;
    rstn = 1'b0;
    rxWr = 1'b1;
    rxData = 8'hAA;
    settle(2);
    rstn = 1'b1;
    settle(1);
    checkOutput("relacc_busy", 32'(busy), 32'd1);
    rxWr = 1'b0;
    rxData = 8'h00;
    settle(2);
    mark();
    pkt = '{8'h00, 8'h40, 8'h01, 8'h99};
    sendPacket();
    settle(4);
    checkCounts("relacc", 1, 1, 0);
    checkWrite("relacc0", 0, 12'h040, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, packet start marker.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, text-buffer address width.
REQ-003 SHALL have parameter MAX_ADDR, default 2399, last valid buffer address (80x30 cells).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 10210000, inter-byte timeout (~100 ms at 102.1 MHz).
REQ-005 SHALL have port clk_i  input  1  system clock (102.1 MHz).
REQ-006 SHALL have port rstn_i  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port rx_wr_i  input  1  UART byte-valid level; may stay high for many cycles per byte.
REQ-008 SHALL have port rx_data_i  input  8  UART received byte, stable while rx_wr_i high.
REQ-009 SHALL have port buf_we_o  output  1  buffer write request.
REQ-010 SHALL have port buf_ready_i  input  1  buffer accepts write this cycle.
REQ-011 SHALL have port buf_addr_o  output  ADDR_WIDTH  write address.
REQ-012 SHALL have port buf_data_o  output  8  write data.
REQ-013 SHALL have port busy_o  output  1  high when state != IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse, packet fully accepted.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse, packet aborted.

Function
REQ-016 SHALL register rx_wr_i into rx_wr_q; byte accepted ("acc") in the cycle rx_wr_i=1 and rx_wr_q=0; exactly one acc per rx_wr_i high period.
REQ-017 SHALL implement states IDLE, ADDR_HI, ADDR_LO, COUNT, DATA.
REQ-018 IDLE: acc with rx_data_i==SYNC_BYTE -> ADDR_HI; any other byte ignored, no err.
REQ-019 ADDR_HI: acc stores byte as addr[15:8] -> ADDR_LO.
REQ-020 ADDR_LO: acc forms 16-bit addr; addr>MAX_ADDR -> err_o pulse, IDLE; else load write pointer with addr[ADDR_WIDTH-1:0] -> COUNT.
REQ-021 COUNT: acc loads remaining count N = byte, with 0 meaning 256 (9-bit counter) -> DATA.
REQ-022 DATA: each acc loads byte into single holding register, sets pending, decrements count; after last byte -> IDLE with done_o pulse in the cycle following that acc.
REQ-023 buf_we_o SHALL equal pending; asserted the cycle after the acc that loaded it; buf_addr_o/buf_data_o stable while buf_we_o high.
REQ-024 Write completes on buf_we_o && buf_ready_i; pending clears next cycle and pointer increments; pointer==MAX_ADDR wraps to 0.
REQ-025 acc in DATA while pending still set (buffer stalled a full byte time): byte discarded, err_o pulse, -> IDLE; pending write still completes normally.
REQ-026 Write completion and new acc in same cycle SHALL NOT be an overflow; holding register reloads, pending stays 1.
REQ-027 Pending write completing after return to IDLE SHALL proceed unaffected; a new SYNC may be accepted meanwhile.
REQ-028 Timeout counter clears on every acc and while IDLE; reaching TIMEOUT_CYCLES-1 in non-IDLE state -> err_o pulse, IDLE.
REQ-029 done_o and err_o SHALL never assert in the same cycle; abort takes precedence if both conditions coincide.
REQ-030 rx_data_i SHALL be sampled only on acc cycles.

Reset
REQ-031 rstn_i low SHALL immediately force state IDLE, pending 0, count 0, pointer 0, timeout 0, rx_wr_q 0.
REQ-032 Outputs in reset: buf_we_o 0, buf_addr_o 0, buf_data_o 0, busy_o 0, done_o 0, err_o 0.
REQ-033 Reset mid-packet or with write pending SHALL drop all state; no write issued after release.
REQ-034 rx_wr_i high at reset release SHALL produce an acc (rx_wr_q=0), treated per current state.

Verification
REQ-035 Bytes AA 00 05 03 41 42 43, buf_ready_i=1 -> writes (5,41),(6,42),(7,43), one done_o pulse, busy_o low after.
REQ-036 AA 09 5F 02 58 59 -> writes (2399,58),(0,59) wrap, done_o pulse.
REQ-037 AA 09 60 ... -> err_o pulse after 3rd byte, no buf_we_o, IDLE; following AA accepted.
REQ-038 buf_ready_i=0 held, AA 00 00 02 11 22 -> buf_we_o holds (0,11), err_o on byte 22, IDLE; release ready -> single write (0,11).
REQ-039 AA 00 10 then silence TIMEOUT_CYCLES -> err_o pulse, IDLE; rx_wr_i held high 20000 cycles per byte -> one acc only.
REQ-040 rstn_i low mid-DATA with pending write -> buf_we_o 0 immediately, no writes after release.
